// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares a single combinational ALU between two requesters. Requests are
// arbitrated round-robin in IDLE; the granted operands and control code are
// latched and presented to the ALU for exactly one EXEC cycle. The ALU
// result and zero flag are then registered and offered on one valid/ready
// response channel, tagged with the id of the requester that issued them.
// Only one operation is ever in flight.
//
// Parameters
//   WIDTH        operand/result width, must match the ALU datapath
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   req0_valid/ready/a/b/ctl requester 0 request channel
//   req1_valid/ready/a/b/ctl requester 1 request channel
//   alu_a, alu_b, alu_ctl    registered operands/control to the ALU
//   alu_result, alu_zero     combinational ALU outputs
//   rsp_valid/ready          response handshake
//   rsp_id                   requester that issued the response
//   rsp_result, rsp_zero     registered ALU result and zero flag
//   busy                     high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctl,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctl,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Requester channels gathered into arrays so the arbitration and
    // operand selection can be written once for both requesters.
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req_a   [2];
    logic [WIDTH-1:0] req_b   [2];
    logic [3:0]       req_ctl [2];

    assign req_valid  = {req1_valid, req0_valid};
    assign req_a[0]   = req0_a;
    assign req_a[1]   = req1_a;
    assign req_b[0]   = req0_b;
    assign req_b[1]   = req1_b;
    assign req_ctl[0] = req0_ctl;
    assign req_ctl[1] = req1_ctl;
    assign req0_ready = req_ready[0];
    assign req1_ready = req_ready[1];

    // Arbitration state and latched operation
    logic             last_grant_reg;
    logic             op_id_reg;
    logic [WIDTH-1:0] alu_a_reg;
    logic [WIDTH-1:0] alu_b_reg;
    logic [3:0]       alu_ctl_reg;

    // Registered response
    logic             rsp_id_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    logic             rsp_zero_reg;

    // Arbitration decision (only meaningful in IDLE)
    logic grant_id;
    logic grant_any;
    logic accept;

    // -----------------------------------------------------------------------
    // Round-robin arbitration: a lone requester always wins; on a tie the
    // requester that was not granted last wins. Re-decided every IDLE cycle,
    // so a requester may withdraw or change its request freely until granted.
    // -----------------------------------------------------------------------
    always_comb begin
        grant_id  = 1'b0;
        grant_any = 1'b0;
        case (req_valid)
            2'b01: begin
                grant_id  = 1'b0;
                grant_any = 1'b1;
            end
            2'b10: begin
                grant_id  = 1'b1;
                grant_any = 1'b1;
            end
            2'b11: begin
                grant_id  = ~last_grant_reg;
                grant_any = 1'b1;
            end
            default: begin
                grant_id  = 1'b0;
                grant_any = 1'b0;
            end
        endcase
    end

    // rst_n gates acceptance so both readys read 0 while reset is held,
    // even though IDLE is the reset state and a valid may already be high.
    assign accept = (state_reg == IDLE) && grant_any && rst_n;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. EXEC is always a single cycle because the ALU
    // is purely combinational.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = accept && (grant_id == 1'(gi));
        end
    endgenerate

    always_comb begin
        busy      = 1'b0;
        rsp_valid = 1'b0;
        case (state_reg)
            IDLE: begin
                busy      = 1'b0;
                rsp_valid = 1'b0;
            end
            EXEC: begin
                busy      = 1'b1;
                rsp_valid = 1'b0;
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: begin
                busy      = 1'b0;
                rsp_valid = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Operand registers. These drive the ALU directly, so they are loaded on
    // the request handshake and are already valid throughout EXEC; outside
    // EXEC they simply hold the last operation.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_reg <= 1'b1;
            op_id_reg      <= 1'b0;
            alu_a_reg      <= '0;
            alu_b_reg      <= '0;
            alu_ctl_reg    <= '0;
        end else if (accept) begin
            last_grant_reg <= grant_id;
            op_id_reg      <= grant_id;
            alu_a_reg      <= req_a[grant_id];
            alu_b_reg      <= req_b[grant_id];
            alu_ctl_reg    <= req_ctl[grant_id];
        end
    end

    assign alu_a   = alu_a_reg;
    assign alu_b   = alu_b_reg;
    assign alu_ctl = alu_ctl_reg;

    // -----------------------------------------------------------------------
    // Response registers: captured at the end of EXEC and held unchanged
    // through RESP until the consumer takes them.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_reg     <= 1'b0;
            rsp_result_reg <= '0;
            rsp_zero_reg   <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_id_reg     <= op_id_reg;
            rsp_result_reg <= alu_result;
            rsp_zero_reg   <= alu_zero;
        end
    end

    assign rsp_id     = rsp_id_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_zero   = rsp_zero_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]    req0_ctl = '0, req1_ctl = '0;
    logic [W-1:0]  alu_a, alu_b, alu_result;
    logic [3:0]    alu_ctl;
    logic          alu_zero;
    logic          rsp_valid, rsp_id, rsp_zero, busy;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference view of the arbiter: who was granted last, and what the ALU
    // inputs should currently hold.
    int           model_last_grant = 1;
    logic [W-1:0] model_alu_a = '0, model_alu_b = '0;
    logic [3:0]   model_alu_ctl = '0;
    int           last_obs_id = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctl(req0_ctl),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctl(req1_ctl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural 32-bit ALU semantics.
    function automatic logic [W-1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [3:0] ctl);
        case (ctl)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    // The shared ALU attached to the arbiter.
    always_comb begin
        alu_result = alu_ref(alu_a, alu_b, alu_ctl);
        alu_zero   = (alu_result == '0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1 with the DUT in IDLE.
    task automatic do_op(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                         input logic [3:0] c0,
                         input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                         input logic [3:0] c1,
                         input int hold, input bit keep_valid);
        int g;
        logic [W-1:0] ea, eb, er;
        logic [3:0] ec;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ctl = c0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ctl = c1;
        rsp_ready = 1'b0;
        if (v0 && !v1)      g = 0;
        else if (v1 && !v0) g = 1;
        else                g = 1 - model_last_grant;
        ea = (g == 1) ? a1 : a0;
        eb = (g == 1) ? b1 : b0;
        ec = (g == 1) ? c1 : c0;
        er = alu_ref(ea, eb, ec);

        @(negedge clk);
        check("req0_ready", 64'(req0_ready), 64'(g == 0));
        check("req1_ready", 64'(req1_ready), 64'(g == 1));
        check("idle_busy", 64'(busy), 64'd0);
        model_last_grant = g;
        model_alu_a = ea; model_alu_b = eb; model_alu_ctl = ec;

        @(posedge clk); #1;
        if (!keep_valid) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        // Scramble the request inputs: the DUT must work from latched copies.
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        req0_ctl = 4'($urandom); req1_ctl = 4'($urandom);
        rsp_ready = (hold == 0);
        @(negedge clk);
        check("exec_busy", 64'(busy), 64'd1);
        check("exec_rsp_valid", 64'(rsp_valid), 64'd0);
        check("exec_alu_a", 64'(alu_a), 64'(ea));
        check("exec_alu_b", 64'(alu_b), 64'(eb));
        check("exec_alu_ctl", 64'(alu_ctl), 64'(ec));
        check("exec_readys", 64'({req1_ready, req0_ready}), 64'd0);

        @(posedge clk); #1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_id", 64'(rsp_id), 64'(g));
            check("hold_rsp_result", 64'(rsp_result), 64'(er));
            check("hold_rsp_zero", 64'(rsp_zero), 64'(er == '0));
            check("hold_readys", 64'({req1_ready, req0_ready}), 64'd0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rsp_valid", 64'(rsp_valid), 64'd1);
        check("rsp_id", 64'(rsp_id), 64'(g));
        check("rsp_result", 64'(rsp_result), 64'(er));
        check("rsp_zero", 64'(rsp_zero), 64'(er == '0));
        check("rsp_readys", 64'({req1_ready, req0_ready}), 64'd0);
        last_obs_id = int'(rsp_id);
        $display("op grant=%0d a=%h b=%h ctl=%b hold=%0d result=%h zero=%0b id=%0b",
                 g, ea, eb, ec, hold, rsp_result, rsp_zero, rsp_id);

        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("back_idle_busy", 64'(busy), 64'd0);
        check("back_idle_rsp_valid", 64'(rsp_valid), 64'd0);
    endtask

    // n idle cycles with no valid requests; entered/left at posedge+1.
    task automatic idle_cycles(input int n);
        req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            req0_a = $urandom; req1_b = $urandom; req0_ctl = 4'($urandom);
            @(negedge clk);
            check("idle_readys", 64'({req1_ready, req0_ready}), 64'd0);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_alu_a", 64'(alu_a), 64'(model_alu_a));
            check("idle_alu_b", 64'(alu_b), 64'(model_alu_b));
            check("idle_alu_ctl", 64'(alu_ctl), 64'(model_alu_ctl));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [3:0] ctl_tab [6];
        ctl_tab[0] = 4'b0010; ctl_tab[1] = 4'b0110; ctl_tab[2] = 4'b0000;
        ctl_tab[3] = 4'b0001; ctl_tab[4] = 4'b0111; ctl_tab[5] = 4'b1010;

        // Reset state, with a valid request pending during reset.
        req0_valid = 1'b1; req1_valid = 1'b1;
        #12;
        check("rst_readys", 64'({req1_ready, req0_ready}), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_result", 64'(rsp_result), 64'd0);
        check("rst_rsp_zero", 64'(rsp_zero), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_alu_ctl", 64'(alu_ctl), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed operations.
        do_op(1, 32'd5, 32'd7, 4'b0010, 0, 32'd0, 32'd0, 4'b0000, 0, 0);
        do_op(0, 32'd0, 32'd0, 4'b0000, 1, 32'd3, 32'd3, 4'b0110, 0, 0);
        do_op(0, 32'd0, 32'd0, 4'b0000, 1, 32'd9, 32'd9, 4'b1111, 0, 0);
        do_op(1, 32'hFFFFFFFF, 32'd1, 4'b0111, 0, 32'd0, 32'd0, 4'b0000, 0, 0);
        do_op(1, 32'd1, 32'hFFFFFFFF, 4'b0111, 0, 32'd0, 32'd0, 4'b0000, 0, 0);
        // Backpressure: response held for 4 cycles.
        do_op(1, 32'd8, 32'd3, 4'b0001, 0, 32'd0, 32'd0, 4'b0000, 4, 0);
        check("bp_result_const", 64'(rsp_result), 64'd11);

        idle_cycles(10);

        // Reset in the middle of an AND operation.
        req0_valid = 1'b1; req0_a = 32'hF0; req0_b = 32'h3C; req0_ctl = 4'b0000;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("mid_exec_busy", 64'(busy), 64'd1);
        check("mid_exec_alu_a", 64'(alu_a), 64'hF0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_alu_ctl", 64'(alu_ctl), 64'd0);
        check("mid_rst_alu_a", 64'(alu_a), 64'd0);
        check("mid_rst_alu_b", 64'(alu_b), 64'd0);
        check("mid_rst_rsp_result", 64'(rsp_result), 64'd0);
        check("mid_rst_rsp_zero", 64'(rsp_zero), 64'd0);
        $display("reset asserted during EXEC");
        #2 rst_n = 1'b1;
        model_last_grant = 1;
        model_alu_a = '0; model_alu_b = '0; model_alu_ctl = '0;
        @(posedge clk); #1;
        idle_cycles(2);

        // Fairness: both requesters continuously valid.
        for (int i = 0; i < 6; i++) begin
            do_op(1, $urandom, $urandom, 4'b0010, 1, $urandom, $urandom, 4'b0110, 0, 1);
            check("fair_order", 64'(last_obs_id), 64'(i % 2));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Randomized operations with random gaps and backpressure.
        for (int i = 0; i < 30; i++) begin
            int vp;
            vp = int'($urandom_range(1, 3));
            do_op(vp[0], $urandom, $urandom, ctl_tab[$urandom_range(0, 5)],
                  vp[1], $urandom, $urandom, ctl_tab[$urandom_range(0, 5)],
                  int'($urandom_range(0, 2)), 0);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
